// File: rtl/sdr_cmd_monitor.sv
// SDR SDRAM command-bus monitor: decodes pin commands, tracks init,
// mode register and bank state, checks spacing, predicts data windows.
module sdr_cmd_monitor #(
  parameter int SDR_BA_WIDTH = 2,
  parameter int SDR_A_WIDTH  = 12,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int T_MRD        = 2,
  parameter int T_RCD        = 2
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic                          sdr_CKE,
  input  logic                          sdr_CSn,
  input  logic                          sdr_RASn,
  input  logic                          sdr_CASn,
  input  logic                          sdr_WEn,
  input  logic [SDR_BA_WIDTH-1:0]       sdr_BA,
  input  logic [SDR_A_WIDTH-1:0]        sdr_A,
  output logic                          cmd_valid,
  output logic [3:0]                    cmd_code,
  output logic [SDR_BA_WIDTH-1:0]       cmd_ba,
  output logic [SDR_A_WIDTH-1:0]        cmd_addr,
  output logic                          init_done,
  output logic [9:0]                    mode_reg,
  output logic [(2**SDR_BA_WIDTH)-1:0]  bank_open,
  output logic                          rd_valid,
  output logic                          wr_valid,
  output logic                          err_pulse,
  output logic                          err_init,
  output logic                          err_timing,
  output logic                          err_bank
);

  localparam int NB = 2**SDR_BA_WIDTH;
  localparam int CW = 8;

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    M_PWR, M_PRE, M_AR1, M_AR2, M_MRS, M_READY
  } mstate_t;

  function automatic cnt_t ld(input int t);
    return (t > 0) ? cnt_t'(t - 1) : '0;
  endfunction

  mstate_t state, state_nx;

  logic [3:0] code;
  logic       live, a10;
  logic       is_act, is_rd, is_wr, is_pre;
  logic       is_ar, is_lmr, is_bt;
  logic       ready, expect_ok, advance;
  logic       t_raw, b_raw, lmr_bad, trp_any;
  logic       i_err, t_err, b_err, accept, mode_ok;
  logic [3:0] bl;
  logic [2:0] cl;

  cnt_t       trp  [NB];
  cnt_t       trcd [NB];
  logic [3:0] ap   [NB];
  cnt_t       trfc, tmrd;

  logic [2:0] rd_wait;
  logic [3:0] rd_beats, wr_beats;

  assign code   = {sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn};
  assign live   = sdr_CKE && !sdr_CSn && (code != 4'b0111);
  assign a10    = sdr_A[10];
  assign is_act = live && (code == 4'b0011);
  assign is_rd  = live && (code == 4'b0101);
  assign is_wr  = live && (code == 4'b0100);
  assign is_pre = live && (code == 4'b0010);
  assign is_ar  = live && (code == 4'b0001);
  assign is_lmr = live && (code == 4'b0000);
  assign is_bt  = live && (code == 4'b0110);

  assign ready     = (state == M_READY);
  assign init_done = ready;
  assign cl        = mode_reg[6:4];

  always_comb begin
    bl = 4'd8;
    unique case (mode_reg[2:0])
      3'd0:    bl = 4'd1;
      3'd1:    bl = 4'd2;
      3'd2:    bl = 4'd4;
      default: bl = 4'd8;
    endcase
  end

  always_comb begin
    trp_any = 1'b0;
    for (int b = 0; b < NB; b++)
      trp_any = trp_any | (trp[b] != '0);
  end

  // Raw rule checks; only charged to commands that take effect.
  always_comb begin
    t_raw   = (trfc != '0) || (tmrd != '0);
    b_raw   = 1'b0;
    lmr_bad = (sdr_A[2:0] > 3'd3) ||
              !((sdr_A[6:4] == 3'd2) || (sdr_A[6:4] == 3'd3)) ||
              (sdr_BA != '0);
    unique case (1'b1)
      is_act: begin
        b_raw = bank_open[sdr_BA];
        t_raw = t_raw || (trp[sdr_BA] != '0);
      end
      is_rd, is_wr: begin
        b_raw = !bank_open[sdr_BA];
        t_raw = t_raw || (trcd[sdr_BA] != '0);
      end
      is_ar, is_lmr: begin
        b_raw = |bank_open;
        t_raw = t_raw || trp_any;
      end
      default: ;
    endcase
  end

  always_comb begin
    expect_ok = 1'b0;
    unique case (state)
      M_PRE:        expect_ok = is_pre && a10;
      M_AR1, M_AR2: expect_ok = is_ar;
      M_MRS:        expect_ok = is_lmr;
      default:      expect_ok = 1'b0;
    endcase
  end

  assign i_err   = live && ((!ready && !expect_ok) || (is_lmr && lmr_bad));
  assign accept  = live && !i_err;
  assign t_err   = accept && t_raw;
  assign b_err   = accept && b_raw;
  assign advance = accept && !ready && !t_raw && !b_raw;
  assign mode_ok = accept && is_lmr && !t_raw && !b_raw;

  always_comb begin
    state_nx = state;
    unique case (state)
      M_PWR:   if (sdr_CKE) state_nx = M_PRE;
      M_PRE:   if (advance) state_nx = M_AR1;
      M_AR1:   if (advance) state_nx = M_AR2;
      M_AR2:   if (advance) state_nx = M_MRS;
      M_MRS:   if (advance) state_nx = M_READY;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= M_PWR;
    else        state <= state_nx;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      cmd_ba     <= '0;
      cmd_addr   <= '0;
      mode_reg   <= '0;
      bank_open  <= '0;
      err_pulse  <= 1'b0;
      err_init   <= 1'b0;
      err_timing <= 1'b0;
      err_bank   <= 1'b0;
      trfc       <= '0;
      tmrd       <= '0;
      rd_valid   <= 1'b0;
      wr_valid   <= 1'b0;
      rd_wait    <= '0;
      rd_beats   <= '0;
      wr_beats   <= '0;
      for (int b = 0; b < NB; b++) begin
        trp[b]  <= '0;
        trcd[b] <= '0;
        ap[b]   <= '0;
      end
    end else begin
      cmd_valid <= live;
      if (live) begin
        cmd_code <= code;
        cmd_ba   <= sdr_BA;
        cmd_addr <= sdr_A;
      end
      err_pulse  <= i_err || t_err || b_err;
      err_init   <= err_init | i_err;
      err_timing <= err_timing | t_err;
      err_bank   <= err_bank | b_err;
      if (mode_ok) mode_reg <= sdr_A[9:0];

      if (trfc != '0) trfc <= trfc - 1'b1;
      if (tmrd != '0) tmrd <= tmrd - 1'b1;
      if (accept && is_ar)  trfc <= ld(T_RFC);
      if (mode_ok)          tmrd <= ld(T_MRD);

      for (int b = 0; b < NB; b++) begin
        if (trp[b] != '0)  trp[b]  <= trp[b] - 1'b1;
        if (trcd[b] != '0) trcd[b] <= trcd[b] - 1'b1;
        // Auto-precharge closes the bank when its burst ends.
        if (ap[b] != '0) begin
          ap[b] <= ap[b] - 1'b1;
          if (ap[b] == 4'd1) begin
            bank_open[b] <= 1'b0;
            trp[b]       <= ld(T_RP);
          end
        end
        if (accept && is_pre &&
            (a10 || (sdr_BA == SDR_BA_WIDTH'(b)))) begin
          bank_open[b] <= 1'b0;
          trp[b]       <= ld(T_RP);
          ap[b]        <= '0;
        end
      end
      if (accept && is_act) begin
        bank_open[sdr_BA] <= 1'b1;
        trcd[sdr_BA]      <= ld(T_RCD);
      end
      if (accept && (is_rd || is_wr) && a10)
        ap[sdr_BA] <= bl;

      if (rd_wait != '0) rd_wait <= rd_wait - 1'b1;
      if (rd_wait == 3'd1) begin
        rd_valid <= 1'b1;
      end else if (rd_valid) begin
        if (rd_beats == '0) rd_valid <= 1'b0;
        else                rd_beats <= rd_beats - 1'b1;
      end
      if (wr_valid) begin
        if (wr_beats == '0) wr_valid <= 1'b0;
        else                wr_beats <= wr_beats - 1'b1;
      end

      if (accept && is_rd) begin
        rd_wait  <= cl;
        rd_valid <= 1'b0;
        rd_beats <= bl - 1'b1;
        wr_valid <= 1'b0;
        wr_beats <= '0;
      end
      if (accept && is_wr) begin
        wr_valid <= 1'b1;
        wr_beats <= bl - 1'b1;
        rd_valid <= 1'b0;
        rd_wait  <= '0;
      end
      if (accept && is_bt) begin
        rd_valid <= 1'b0;
        rd_wait  <= '0;
        wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// Directed bench for sdr_cmd_monitor: init, bursts, spacing,
// bank rules and mid-burst reset.
module tb_sdr_cmd_monitor;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_AR  = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;
  localparam logic [3:0] C_BT  = 4'b0110;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        sdr_CKE = 1'b0;
  logic        sdr_CSn = 1'b0;
  logic        sdr_RASn = 1'b1;
  logic        sdr_CASn = 1'b1;
  logic        sdr_WEn = 1'b1;
  logic [1:0]  sdr_BA = '0;
  logic [11:0] sdr_A = '0;
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic [1:0]  cmd_ba;
  logic [11:0] cmd_addr;
  logic        init_done;
  logic [9:0]  mode_reg;
  logic [3:0]  bank_open;
  logic        rd_valid, wr_valid, err_pulse;
  logic        err_init, err_timing, err_bank;

  int total = 0;
  int bad = 0;

  always #5 pclk = ~pclk;

  sdr_cmd_monitor dut (
    .pclk(pclk), .preset(preset), .sdr_CKE(sdr_CKE),
    .sdr_CSn(sdr_CSn), .sdr_RASn(sdr_RASn),
    .sdr_CASn(sdr_CASn), .sdr_WEn(sdr_WEn),
    .sdr_BA(sdr_BA), .sdr_A(sdr_A),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
    .init_done(init_done), .mode_reg(mode_reg),
    .bank_open(bank_open), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .err_pulse(err_pulse),
    .err_init(err_init), .err_timing(err_timing),
    .err_bank(err_bank)
  );

  task automatic cyc(input logic [3:0] c, input logic [1:0] b,
                     input logic [11:0] a);
    {sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn} = c;
    sdr_BA = b;
    sdr_A = a;
    @(posedge pclk);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(C_NOP, 2'd0, 12'h000);
  endtask

  task automatic do_reset();
    preset = 1'b1;
    sdr_CKE = 1'b0;
    {sdr_CSn, sdr_RASn, sdr_CASn, sdr_WEn} = C_NOP;
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
  endtask

  task automatic do_init(input logic [11:0] mode);
    sdr_CKE = 1'b1;
    nop(1);
    cyc(C_PRE, 2'd0, 12'h400);
    nop(2);
    cyc(C_AR, 2'd0, 12'h000);
    nop(7);
    cyc(C_AR, 2'd0, 12'h000);
    nop(7);
    cyc(C_LMR, 2'd0, mode);
    nop(2);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({cmd_valid, init_done, rd_valid, wr_valid, err_pulse} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000",
               {cmd_valid, init_done, rd_valid, wr_valid, err_pulse});
    end
    total++;
    if ({mode_reg, bank_open, err_init, err_timing, err_bank} !== 17'h0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0",
               {mode_reg, bank_open, err_init, err_timing, err_bank});
    end
  endtask

  task automatic test_init();
    do_reset();
    sdr_CKE = 1'b1;
    nop(1);
    cyc(C_PRE, 2'd0, 12'h400);
    total++;
    if ({cmd_valid, cmd_code, init_done} !== 6'b1_0010_0) begin
      bad++;
      $display("FAIL init_pre got=%b exp=100100",
               {cmd_valid, cmd_code, init_done});
    end
    nop(2);
    cyc(C_AR, 2'd0, 12'h000);
    nop(7);
    cyc(C_AR, 2'd0, 12'h000);
    nop(7);
    cyc(C_LMR, 2'd0, 12'h022);
    total++;
    if ({cmd_valid, cmd_code, init_done} !== 6'b1_0000_1) begin
      bad++;
      $display("FAIL init_lmr got=%b exp=100001",
               {cmd_valid, cmd_code, init_done});
    end
    total++;
    if (cmd_addr !== 12'h022) begin
      bad++;
      $display("FAIL init_addr got=%h exp=022", cmd_addr);
    end
    nop(2);
    total++;
    if ({init_done, mode_reg} !== {1'b1, 10'h022}) begin
      bad++;
      $display("FAIL init_mode got=%b/%h exp=1/022", init_done, mode_reg);
    end
    total++;
    if ({cmd_valid, err_init, err_timing, err_bank} !== 4'b0) begin
      bad++;
      $display("FAIL init_errs got=%b exp=0000",
               {cmd_valid, err_init, err_timing, err_bank});
    end
  endtask

  task automatic test_read();
    logic [5:0] rd_exp;
    logic [5:0] op_exp;
    rd_exp = 6'b011110;
    op_exp = 6'b000111;
    cyc(C_ACT, 2'd1, 12'h1A5);
    total++;
    if ({bank_open, cmd_ba, cmd_addr} !== {4'b0010, 2'd1, 12'h1A5}) begin
      bad++;
      $display("FAIL act_open got=%b/%h exp=0010/1a5", bank_open, cmd_addr);
    end
    nop(2);
    cyc(C_RD, 2'd1, 12'h40F);
    total++;
    if ({cmd_valid, cmd_code, cmd_addr, rd_valid} !==
        {1'b1, C_RD, 12'h40F, 1'b0}) begin
      bad++;
      $display("FAIL rd_cmd got=%b/%b/%h/%b exp=1/0101/40f/0",
               cmd_valid, cmd_code, cmd_addr, rd_valid);
    end
    for (int k = 1; k <= 6; k++) begin
      nop(1);
      total++;
      if ({rd_valid, bank_open[1]} !== {rd_exp[k-1], op_exp[k-1]}) begin
        bad++;
        $display("FAIL rd_win k=%0d got=%b%b exp=%b%b", k, rd_valid,
                 bank_open[1], rd_exp[k-1], op_exp[k-1]);
      end
    end
    total++;
    if ({wr_valid, err_init, err_timing, err_bank} !== 4'b0) begin
      bad++;
      $display("FAIL rd_errs got=%b exp=0000",
               {wr_valid, err_init, err_timing, err_bank});
    end
  endtask

  task automatic test_write_bt();
    cyc(C_ACT, 2'd3, 12'h033);
    nop(2);
    cyc(C_WR, 2'd3, 12'h010);
    total++;
    if ({wr_valid, rd_valid, cmd_code} !== {2'b10, C_WR}) begin
      bad++;
      $display("FAIL wr_start got=%b%b/%b exp=10/0100",
               wr_valid, rd_valid, cmd_code);
    end
    nop(1);
    total++;
    if (wr_valid !== 1'b1) begin
      bad++;
      $display("FAIL wr_beat2 got=%b exp=1", wr_valid);
    end
    cyc(C_BT, 2'd0, 12'h000);
    total++;
    if ({wr_valid, cmd_valid, cmd_code} !== {2'b01, C_BT}) begin
      bad++;
      $display("FAIL bt_clear got=%b%b/%b exp=01/0110",
               wr_valid, cmd_valid, cmd_code);
    end
    cyc(C_PRE, 2'd3, 12'h000);
    total++;
    if ({bank_open, err_init, err_timing, err_bank} !== 7'b0) begin
      bad++;
      $display("FAIL pre_close got=%b exp=0000000",
               {bank_open, err_init, err_timing, err_bank});
    end
  endtask

  task automatic test_trcd();
    cyc(C_ACT, 2'd0, 12'h000);
    cyc(C_RD, 2'd0, 12'h000);
    total++;
    if ({err_pulse, err_timing, err_bank, err_init} !== 4'b1100) begin
      bad++;
      $display("FAIL trcd got=%b exp=1100",
               {err_pulse, err_timing, err_bank, err_init});
    end
    nop(1);
    total++;
    if (err_pulse !== 1'b0) begin
      bad++;
      $display("FAIL trcd_once got=%b exp=0", err_pulse);
    end
  endtask

  task automatic test_refresh();
    do_reset();
    do_init(12'h022);
    cyc(C_ACT, 2'd2, 12'h055);
    nop(1);
    cyc(C_AR, 2'd0, 12'h000);
    total++;
    if ({err_pulse, err_bank, err_timing} !== 3'b110) begin
      bad++;
      $display("FAIL ar_open got=%b exp=110",
               {err_pulse, err_bank, err_timing});
    end
    nop(2);
    cyc(C_AR, 2'd0, 12'h000);
    total++;
    if ({err_pulse, err_timing} !== 2'b11) begin
      bad++;
      $display("FAIL trfc got=%b exp=11", {err_pulse, err_timing});
    end
  endtask

  task automatic test_init_err();
    do_reset();
    sdr_CKE = 1'b1;
    nop(1);
    cyc(C_ACT, 2'd0, 12'h100);
    total++;
    if ({cmd_valid, err_pulse, err_init, init_done} !== 4'b1110) begin
      bad++;
      $display("FAIL early_act got=%b exp=1110",
               {cmd_valid, err_pulse, err_init, init_done});
    end
    do_reset();
    do_init(12'h025);
    total++;
    if ({init_done, err_init, err_timing, mode_reg} !==
        {3'b010, 10'h000}) begin
      bad++;
      $display("FAIL bad_bl got=%b%b%b/%h exp=010/000",
               init_done, err_init, err_timing, mode_reg);
    end
    cyc(C_LMR, 2'd0, 12'h032);
    nop(2);
    total++;
    if ({init_done, mode_reg} !== {1'b1, 10'h032}) begin
      bad++;
      $display("FAIL lmr_retry got=%b/%h exp=1/032", init_done, mode_reg);
    end
  endtask

  task automatic test_preset_midburst();
    do_reset();
    do_init(12'h033);
    cyc(C_ACT, 2'd0, 12'h000);
    nop(2);
    cyc(C_RD, 2'd0, 12'h000);
    nop(2);
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL cl3_wait got=%b exp=0", rd_valid);
    end
    nop(2);
    total++;
    if (rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL cl3_beat got=%b exp=1", rd_valid);
    end
    #2 preset = 1'b1;
    #1;
    total++;
    if ({rd_valid, wr_valid, cmd_valid, init_done, bank_open,
         mode_reg} !== 18'h0) begin
      bad++;
      $display("FAIL async_rst got=%b%b%b%b/%b/%h exp=0",
               rd_valid, wr_valid, cmd_valid, init_done,
               bank_open, mode_reg);
    end
    @(posedge pclk);
    #1 preset = 1'b0;
    sdr_CKE = 1'b1;
    nop(1);
    cyc(C_ACT, 2'd0, 12'h000);
    nop(2);
    total++;
    if ({init_done, err_init} !== 2'b01) begin
      bad++;
      $display("FAIL need_reinit got=%b exp=01", {init_done, err_init});
    end
    do_reset();
    do_init(12'h022);
    total++;
    if ({init_done, err_init} !== 2'b10) begin
      bad++;
      $display("FAIL reinit got=%b exp=10", {init_done, err_init});
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_write_bt();
    test_trcd();
    test_refresh();
    test_init_err();
    test_preset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
